// File: rtl/cam_in_loader.sv
// rtl/cam_in_loader.sv - camera frame loader: byte stream into CAM_SRAM, then column-by-column drain
module cam_in_loader #(
  parameter int ROWS = 26,
  parameter int COLS = 34,
  parameter int DW   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic [DW-1:0]        s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic [DW-1:0]        sram_datain,
  output logic                 sram_wen,
  output logic [9:0]           sram_waddr,
  output logic [9:0]           sram_raddr,
  input  logic [ROWS*DW-1:0]   sram_dataout,
  output logic [ROWS*DW-1:0]   m_col,
  output logic [5:0]           m_col_idx,
  output logic                 m_valid,
  output logic                 m_last,
  input  logic                 m_ready,
  output logic                 frame_done
);

  localparam int         FRAME_BYTES = ROWS * COLS;
  localparam logic [9:0] WCNT_LAST   = 10'(FRAME_BYTES - 1);
  localparam logic [5:0] COL_LAST    = 6'(COLS - 1);

  typedef enum logic {
    LOAD  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [9:0] wcnt;
  logic [5:0] col_ptr;

  logic accept;
  logic handshake;
  logic last_byte;
  logic last_col;
  logic issue_read;

  assign s_ready   = (state == LOAD);
  assign accept    = s_valid && s_ready;
  assign handshake = m_valid && m_ready;
  assign last_byte = (wcnt == WCNT_LAST);
  assign last_col  = (col_ptr == COL_LAST);

  // A read is launched only once the final write has left the bus and no column is pending;
  // the SRAM captures memory[raddr] on that same edge, so m_valid and dataout line up.
  assign issue_read = (state == DRAIN) && !sram_wen && !m_valid;

  // SRAM read address and column index both track the column pointer directly.
  assign sram_raddr = {4'b0000, col_ptr};
  assign m_col_idx  = col_ptr;
  assign m_col      = sram_dataout;
  assign m_last     = m_valid && last_col;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOAD;
    end else begin
      state <= state_next;
    end
  end

  // Next state: clear wins; last byte accepted moves to DRAIN; last column handshake returns to LOAD.
  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = LOAD;
    end else if (state == LOAD) begin
      if (accept && last_byte) begin
        state_next = DRAIN;
      end
    end else begin
      if (handshake && last_col) begin
        state_next = LOAD;
      end
    end
  end

  // Write port: each accepted byte goes onto the SRAM bus one cycle later at its linear address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt        <= '0;
      sram_wen    <= 1'b0;
      sram_waddr  <= '0;
      sram_datain <= '0;
    end else if (clear) begin
      wcnt     <= '0;
      sram_wen <= 1'b0;
    end else if (accept) begin
      sram_wen    <= 1'b1;
      sram_waddr  <= wcnt;
      sram_datain <= s_data;
      wcnt        <= last_byte ? 10'd0 : wcnt + 10'd1;
    end else begin
      sram_wen <= 1'b0;
    end
  end

  // Read sequencer: one read per column, hold on backpressure, pulse frame_done after the last column.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_ptr    <= '0;
      m_valid    <= 1'b0;
      frame_done <= 1'b0;
    end else if (clear) begin
      col_ptr    <= '0;
      m_valid    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (handshake) begin
        m_valid <= 1'b0;
        if (last_col) begin
          col_ptr    <= '0;
          frame_done <= 1'b1;
        end else begin
          col_ptr <= col_ptr + 6'd1;
        end
      end else if (issue_read) begin
        m_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cam_in_loader.sv
// tb/tb_cam_in_loader.sv - directed bench for cam_in_loader with a behavioural CAM_SRAM
module tb_cam_in_loader;

  localparam int ROWS  = 26;
  localparam int COLS  = 34;
  localparam int FRAME = ROWS * COLS;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         clear;
  logic [7:0]   s_data;
  logic         s_valid;
  logic         s_ready;
  logic [7:0]   sram_datain;
  logic         sram_wen;
  logic [9:0]   sram_waddr;
  logic [9:0]   sram_raddr;
  logic [207:0] sram_dataout = '0;
  logic [207:0] m_col;
  logic [5:0]   m_col_idx;
  logic         m_valid;
  logic         m_last;
  logic         m_ready;
  logic         frame_done;

  int tests = 0;
  int fails = 0;
  int wr_count = 0;

  logic [7:0] mem [0:FRAME-1];

  cam_in_loader #(.ROWS(ROWS), .COLS(COLS), .DW(8)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .sram_datain(sram_datain), .sram_wen(sram_wen), .sram_waddr(sram_waddr),
    .sram_raddr(sram_raddr), .sram_dataout(sram_dataout),
    .m_col(m_col), .m_col_idx(m_col_idx), .m_valid(m_valid), .m_last(m_last),
    .m_ready(m_ready), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Behavioural CAM_SRAM: linear byte writes, registered column reads whenever wen is low.
  always @(posedge clk) begin
    if (sram_wen) begin
      if (int'(sram_waddr) < FRAME) mem[sram_waddr] <= sram_datain;
    end else begin
      for (int r = 0; r < ROWS; r++)
        sram_dataout[207-8*r -: 8] <= (int'(sram_raddr) * ROWS + r < FRAME) ? mem[int'(sram_raddr) * ROWS + r] : 8'h00;
    end
  end

  // Write counter used to confirm the number of SRAM writes per frame.
  always @(posedge clk) begin
    if (sram_wen === 1'b1) wr_count <= wr_count + 1;
  end

  function automatic logic [7:0] val(input bit inv, input int k);
    logic [7:0] kb;
    kb = 8'(k);
    return inv ? (8'hFF - kb) : kb;
  endfunction

  function automatic logic [207:0] expcol(input bit inv, input int c);
    logic [207:0] v;
    v = '0;
    for (int r = 0; r < ROWS; r++) v[207-8*r -: 8] = val(inv, c * ROWS + r);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [207:0] obs, input logic [207:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_s_ready"}, s_ready, 1);
    chk({tag, "_wen"}, sram_wen, 0);
    chk({tag, "_waddr"}, sram_waddr, 0);
    chk({tag, "_datain"}, sram_datain, 0);
    chk({tag, "_raddr"}, sram_raddr, 0);
    chk({tag, "_m_valid"}, m_valid, 0);
    chk({tag, "_m_last"}, m_last, 0);
    chk({tag, "_m_col_idx"}, m_col_idx, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
  endtask

  // Offers bytes from..to-1 of a frame; gap is the percentage of idle cycles.
  task automatic send(input bit inv, input int gap, input int from, input int to);
    int k;
    k = from;
    while (k < to) begin
      s_valid = (gap == 0) ? 1'b1 : ($urandom_range(99) >= gap);
      s_data  = val(inv, k);
      chk("load_s_ready", s_ready, 1);
      step();
      if (s_valid) begin
        chk("wr_wen", sram_wen, 1);
        chk("wr_waddr", sram_waddr, k);
        chk("wr_datain", sram_datain, val(inv, k));
        k++;
      end else begin
        chk("gap_wen", sram_wen, 0);
        if (k > from) chk("gap_waddr_hold", sram_waddr, k - 1);
      end
      chk("load_frame_done", frame_done, 0);
    end
    s_valid = 1'b0;
  endtask

  // Entered in the first DRAIN cycle; checks every column. abort_kind 1 = clear at abort_col,
  // 2 = return at abort_col so the caller can reset.
  task automatic drain(input bit inv, input int stall_col, input bit hold,
                       input int abort_col, input int abort_kind);
    m_ready = 1'b1;
    s_valid = hold;
    s_data  = 8'hEE;
    chk("drain_s_ready", s_ready, 0);
    chk("drain_m_valid_t1", m_valid, 0);
    step();
    chk("first_read_wen", sram_wen, 0);
    chk("first_read_raddr", sram_raddr, 0);
    chk("first_read_m_valid", m_valid, 0);
    step();
    for (int c = 0; c < COLS; c++) begin
      chk("col_m_valid", m_valid, 1);
      chk("col_idx", m_col_idx, c);
      chk("col_raddr", sram_raddr, c);
      chk("col_data", m_col, expcol(inv, c));
      chk("col_m_last", m_last, (c == COLS - 1));
      chk("col_frame_done", frame_done, 0);
      chk("col_s_ready", s_ready, 0);
      chk("col_wen", sram_wen, 0);
      if (!inv && c == 0) begin
        chk("col0_row0", m_col[207:200], 8'h00);
        chk("col0_row25", m_col[7:0], 8'h19);
      end
      if (!inv && c == COLS - 1) begin
        chk("col33_row0", m_col[207:200], 8'h5A);
        chk("col33_row25", m_col[7:0], 8'h73);
      end
      if (c == abort_col) begin
        if (abort_kind == 1) begin
          clear = 1'b1;
          step();
          clear = 1'b0;
          chk("clr_drain_s_ready", s_ready, 1);
          chk("clr_drain_m_valid", m_valid, 0);
          chk("clr_drain_col_idx", m_col_idx, 0);
          chk("clr_drain_raddr", sram_raddr, 0);
          chk("clr_drain_wen", sram_wen, 0);
          chk("clr_drain_frame_done", frame_done, 0);
        end
        return;
      end
      if (c == stall_col) begin
        m_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
          step();
          chk("stall_m_valid", m_valid, 1);
          chk("stall_col_data", m_col, expcol(inv, c));
          chk("stall_raddr", sram_raddr, c);
          chk("stall_idx", m_col_idx, c);
        end
        m_ready = 1'b1;
      end
      step();
      if (c < COLS - 1) begin
        chk("gap_m_valid", m_valid, 0);
        chk("gap_read_wen", sram_wen, 0);
        chk("gap_s_ready", s_ready, 0);
        step();
      end else begin
        chk("done_pulse", frame_done, 1);
        chk("done_s_ready", s_ready, 1);
        chk("done_m_valid", m_valid, 0);
        chk("done_m_last", m_last, 0);
      end
    end
  endtask

  initial begin
    int w0;
    rst_n   = 1'b0;
    clear   = 1'b0;
    s_valid = 1'b0;
    s_data  = 8'h00;
    m_ready = 1'b0;
    #12;
    chk_reset_vals("rst_init");
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk_reset_vals("post_rst");

    // Full frame, byte k = k, no gaps.
    w0 = wr_count;
    send(0, 0, 0, FRAME);
    drain(0, -1, 0, -1, 0);
    chk("t1_write_count", wr_count - w0, FRAME);

    // Random s_valid gaps; same column data expected.
    w0 = wr_count;
    send(0, 50, 0, FRAME);
    drain(0, -1, 0, -1, 0);
    chk("t2_write_count", wr_count - w0, FRAME);

    // Backpressure at column 5 with s_valid held through DRAIN.
    send(0, 0, 0, FRAME);
    drain(0, 5, 1, -1, 0);

    // Acceptance resumes in the frame_done cycle; clear after 100 bytes.
    send(0, 0, 0, 100);
    clear   = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'h77;
    step();
    clear   = 1'b0;
    s_valid = 1'b0;
    chk("clr_load_wen", sram_wen, 0);
    chk("clr_load_s_ready", s_ready, 1);
    chk("clr_load_m_valid", m_valid, 0);
    send(0, 0, 0, FRAME);
    drain(0, -1, 0, 10, 1);
    send(1, 0, 0, FRAME);
    drain(1, -1, 0, -1, 0);

    // Asynchronous reset mid-DRAIN, then two back-to-back frames.
    send(0, 0, 0, FRAME);
    drain(0, -1, 0, 7, 2);
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    step();
    step();
    chk_reset_vals("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    step();
    send(1, 0, 0, FRAME);
    drain(1, -1, 0, -1, 0);
    send(0, 30, 0, FRAME);
    drain(0, -1, 0, -1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
